regfile_access_arbiter: RTL and testbench

- Sequences and shares the single-access 32x32 register file between two requesters: port 0 (core) and port 1 (debug/loader).
- Converts per-requester valid/done transactions into the register file's do_reg_fetch / do_reg_write / enable_reg_write strobe protocol.
- Captures registered read data one cycle after the fetch strobe and returns it to the granted requester.
- Sits between the core control unit and the register file; only one transaction is in flight at a time.

---
 rtl/regfile_access_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// Shares the single-access register file between port 0 (core) and port 1 (debug/loader).
// Optional macro REGFILE_ARB_R0_PROTECT_EN: writes to address 0 leave enable_reg_write low.
module regfile_access_arbiter #(
    parameter int unsigned DataSize = 32,
    parameter int unsigned AddrSize = 5
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                r0_valid,
    input  logic                r0_write,
    input  logic [AddrSize-1:0] r0_addr1,
    input  logic [AddrSize-1:0] r0_addr2,
    input  logic [DataSize-1:0] r0_wdata,
    output logic                r0_done,
    output logic [DataSize-1:0] r0_rdata1,
    output logic [DataSize-1:0] r0_rdata2,

    input  logic                r1_valid,
    input  logic                r1_write,
    input  logic [AddrSize-1:0] r1_addr1,
    input  logic [AddrSize-1:0] r1_addr2,
    input  logic [DataSize-1:0] r1_wdata,
    output logic                r1_done,
    output logic [DataSize-1:0] r1_rdata1,
    output logic [DataSize-1:0] r1_rdata2,

    output logic [AddrSize-1:0] rf_read_addr1,
    output logic [AddrSize-1:0] rf_read_addr2,
    output logic [AddrSize-1:0] rf_write_addr,
    output logic [DataSize-1:0] rf_write_data,
    output logic                rf_enable_write,
    output logic                rf_do_fetch,
    output logic                rf_do_write,
    input  logic [DataSize-1:0] rf_read_data1,
    input  logic [DataSize-1:0] rf_read_data2,

    output logic                busy,
    output logic                grant_id
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_grant;
    logic                r_last_grant;

    logic                w_take;
    logic                w_pick;
    logic                w_sel_write;
    logic [AddrSize-1:0] w_sel_addr1;
    logic [AddrSize-1:0] w_sel_addr2;
    logic [DataSize-1:0] w_sel_wdata;
    logic                w_wr_allowed;

    logic                w_busy_next;
    logic                w_grant_id_next;
    logic                w_do_fetch_next;
    logic                w_do_write_next;
    logic                w_enable_write_next;
    logic                w_r0_done_next;
    logic                w_r1_done_next;
    logic [AddrSize-1:0] w_read_addr1_next;
    logic [AddrSize-1:0] w_read_addr2_next;
    logic [AddrSize-1:0] w_write_addr_next;
    logic [DataSize-1:0] w_write_data_next;

    // Round-robin pick: on a tie the port not granted last wins; a lone valid always wins.
    always_comb begin
        w_take = 1'b0;
        w_pick = r_grant;
        if (r_state == S_IDLE) begin
            if (r0_valid && r1_valid) begin
                w_take = 1'b1;
                w_pick = ~r_last_grant;
            end else if (r0_valid) begin
                w_take = 1'b1;
                w_pick = 1'b0;
            end else if (r1_valid) begin
                w_take = 1'b1;
                w_pick = 1'b1;
            end
        end
    end

    // Request fields of the picked port, consumed only on the grant cycle.
    always_comb begin
        w_sel_write = r0_write;
        w_sel_addr1 = r0_addr1;
        w_sel_addr2 = r0_addr2;
        w_sel_wdata = r0_wdata;
        if (w_pick) begin
            w_sel_write = r1_write;
            w_sel_addr1 = r1_addr1;
            w_sel_addr2 = r1_addr2;
            w_sel_wdata = r1_wdata;
        end
    end

`ifdef REGFILE_ARB_R0_PROTECT_EN
    assign w_wr_allowed = (w_sel_addr1 != '0);
`else
    assign w_wr_allowed = 1'b1;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        w_state_next        = r_state;
        w_do_fetch_next     = 1'b0;
        w_do_write_next     = 1'b0;
        w_enable_write_next = 1'b0;
        w_r0_done_next      = 1'b0;
        w_r1_done_next      = 1'b0;
        w_read_addr1_next   = '0;
        w_read_addr2_next   = '0;
        w_write_addr_next   = '0;
        w_write_data_next   = '0;

        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    if (w_sel_write) begin
                        w_state_next        = S_WRITE;
                        w_do_write_next     = 1'b1;
                        w_enable_write_next = w_wr_allowed;
                        w_write_addr_next   = w_sel_addr1;
                        w_write_data_next   = w_sel_wdata;
                    end else begin
                        w_state_next      = S_FETCH;
                        w_do_fetch_next   = 1'b1;
                        w_read_addr1_next = w_sel_addr1;
                        w_read_addr2_next = w_sel_addr2;
                    end
                end
            end
            S_FETCH: begin
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE, S_WRITE: begin
                w_state_next   = S_RESP;
                w_r0_done_next = ~r_grant;
                w_r1_done_next = r_grant;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next     = (w_state_next != S_IDLE);
        w_grant_id_next = w_busy_next ? (w_take ? w_pick : r_grant) : 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy            <= 1'b0;
            grant_id        <= 1'b0;
            rf_do_fetch     <= 1'b0;
            rf_do_write     <= 1'b0;
            rf_enable_write <= 1'b0;
            rf_read_addr1   <= '0;
            rf_read_addr2   <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            r0_done         <= 1'b0;
            r1_done         <= 1'b0;
        end else begin
            busy            <= w_busy_next;
            grant_id        <= w_grant_id_next;
            rf_do_fetch     <= w_do_fetch_next;
            rf_do_write     <= w_do_write_next;
            rf_enable_write <= w_enable_write_next;
            rf_read_addr1   <= w_read_addr1_next;
            rf_read_addr2   <= w_read_addr2_next;
            rf_write_addr   <= w_write_addr_next;
            rf_write_data   <= w_write_data_next;
            r0_done         <= w_r0_done_next;
            r1_done         <= w_r1_done_next;
        end
    end

    // Register-file data is valid during CAPTURE; only the granted port's rdata moves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r0_rdata1 <= '0;
            r0_rdata2 <= '0;
            r1_rdata1 <= '0;
            r1_rdata2 <= '0;
        end else if (r_state == S_CAPTURE) begin
            if (r_grant) begin
                r1_rdata1 <= rf_read_data1;
                r1_rdata2 <= rf_read_data2;
            end else begin
                r0_rdata1 <= rf_read_data1;
                r0_rdata2 <= rf_read_data2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench for regfile_access_arbiter with a register-file stub and a scoreboard model.
module tb_regfile_access_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef REGFILE_ARB_R0_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          r0_valid, r0_write, r1_valid, r1_write;
    logic [AW-1:0] r0_addr1, r0_addr2, r1_addr1, r1_addr2;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_done, r1_done;
    logic [DW-1:0] r0_rdata1, r0_rdata2, r1_rdata1, r1_rdata2;
    logic [AW-1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic          rf_enable_write, rf_do_fetch, rf_do_write;
    logic [DW-1:0] rf_read_data1 = '0;
    logic [DW-1:0] rf_read_data2 = '0;
    logic          busy, grant_id;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] init_val [32];
    logic [DW-1:0] rf_mem   [32];
    logic          mem_init_done = 1'b0;
    logic [DW-1:0] exp_mem  [32];
    logic [DW-1:0] exp_rd1  [2];
    logic [DW-1:0] exp_rd2  [2];
    int            exp_last;

    regfile_access_arbiter #(.DataSize(DW), .AddrSize(AW)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr1(r0_addr1), .r0_addr2(r0_addr2),
        .r0_wdata(r0_wdata), .r0_done(r0_done), .r0_rdata1(r0_rdata1), .r0_rdata2(r0_rdata2),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr1(r1_addr1), .r1_addr2(r1_addr2),
        .r1_wdata(r1_wdata), .r1_done(r1_done), .r1_rdata1(r1_rdata1), .r1_rdata2(r1_rdata2),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_enable_write(rf_enable_write), .rf_do_fetch(rf_do_fetch), .rf_do_write(rf_do_write),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    // Register file stub: registered read on fetch, write when both write strobes are high.
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val[i];
            mem_init_done <= 1'b1;
        end else begin
            if (rf_do_fetch) begin
                rf_read_data1 <= rf_mem[rf_read_addr1];
                rf_read_data2 <= rf_mem[rf_read_addr2];
            end
            if (rf_do_write && rf_enable_write) rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    function automatic logic done_of(input int p);
        return (p == 1) ? r1_done : r0_done;
    endfunction

    function automatic logic [DW-1:0] rd1_of(input int p);
        return (p == 1) ? r1_rdata1 : r0_rdata1;
    endfunction

    function automatic logic [DW-1:0] rd2_of(input int p);
        return (p == 1) ? r1_rdata2 : r0_rdata2;
    endfunction

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [DW-1:0] d);
        if (p == 1) begin
            r1_valid = v; r1_write = w; r1_addr1 = a1; r1_addr2 = a2; r1_wdata = d;
        end else begin
            r0_valid = v; r0_write = w; r0_addr1 = a1; r0_addr2 = a2; r0_wdata = d;
        end
    endtask

    // One transaction on a single port, called at a negedge while the DUT is idle.
    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] d);
        int cyc = 0;
        int nfetch = 0;
        int nwrite = 0;
        bit seen = 0;
        bit en_exp;
        en_exp = !(PROTECT && a1 == '0);
        set_req(p, 1'b1, w, a1, a2, d);
        while (!seen && cyc < 12) begin
            @(negedge clock);
            cyc++;
            checks++;
            if (rf_do_fetch && rf_do_write) begin
                failures++; $display("FAIL strobe_overlap: fetch=%b write=%b required not both", rf_do_fetch, rf_do_write);
            end
            if (rf_do_fetch) begin
                nfetch++;
                checks++;
                if (rf_read_addr1 !== a1 || rf_read_addr2 !== a2) begin
                    failures++; $display("FAIL fetch_addr: got %0d/%0d required %0d/%0d", rf_read_addr1, rf_read_addr2, a1, a2);
                end
            end else begin
                checks++;
                if (rf_read_addr1 !== '0 || rf_read_addr2 !== '0) begin
                    failures++; $display("FAIL read_addr_idle: got %0d/%0d required 0/0", rf_read_addr1, rf_read_addr2);
                end
            end
            if (rf_do_write) begin
                nwrite++;
                checks++;
                if (rf_write_addr !== a1 || rf_write_data !== d || rf_enable_write !== en_exp) begin
                    failures++; $display("FAIL write_drive: got a=%0d d=%h en=%b required a=%0d d=%h en=%b",
                                         rf_write_addr, rf_write_data, rf_enable_write, a1, d, en_exp);
                end
            end else begin
                checks++;
                if (rf_write_addr !== '0 || rf_write_data !== '0 || rf_enable_write !== 1'b0) begin
                    failures++; $display("FAIL write_idle: got a=%0d d=%h en=%b required zeros", rf_write_addr, rf_write_data, rf_enable_write);
                end
            end
            checks++;
            if (busy !== 1'b1 || grant_id !== 1'(p)) begin
                failures++; $display("FAIL busy_grant: got busy=%b grant=%b required busy=1 grant=%0d", busy, grant_id, p);
            end
            checks++;
            if (done_of(1 - p) !== 1'b0) begin
                failures++; $display("FAIL other_done: port %0d done got 1 required 0", 1 - p);
            end
            if (done_of(p) === 1'b1) seen = 1;
        end
        set_req(p, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL done_timeout: port %0d no done within %0d cycles", p, cyc);
        end
        checks++;
        if (cyc != (w ? 2 : 3)) begin
            failures++; $display("FAIL latency: got %0d required %0d", cyc, w ? 2 : 3);
        end
        checks++;
        if (nfetch != (w ? 0 : 1) || nwrite != (w ? 1 : 0)) begin
            failures++; $display("FAIL strobe_count: got fetch=%0d write=%0d required fetch=%0d write=%0d", nfetch, nwrite, w ? 0 : 1, w ? 1 : 0);
        end
        if (w) begin
            if (en_exp) exp_mem[a1] = d;
        end else begin
            exp_rd1[p] = exp_mem[a1];
            exp_rd2[p] = exp_mem[a2];
        end
        exp_last = p;
        for (int q = 0; q < 2; q++) begin
            checks++;
            if (rd1_of(q) !== exp_rd1[q] || rd2_of(q) !== exp_rd2[q]) begin
                failures++; $display("FAIL rdata_port%0d: got %h/%h required %h/%h", q, rd1_of(q), rd2_of(q), exp_rd1[q], exp_rd2[q]);
            end
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done_of(p) !== 1'b0) begin
            failures++; $display("FAIL back_to_idle: got busy=%b done=%b required 0/0", busy, done_of(p));
        end
    endtask

    // Both ports request reads at once and each holds valid for n transactions.
    task automatic run_both(input int n0, input int n1, output int first_port);
        int n[2];
        int rem[2];
        int got[2];
        int exp_q[$];
        int order_q[$];
        int last;
        int cyc = 0;
        logic [AW-1:0] ad1[2];
        logic [AW-1:0] ad2[2];
        n[0] = n0; n[1] = n1;
        rem[0] = n0; rem[1] = n1;
        got[0] = 0; got[1] = 0;
        last = exp_last;
        while (rem[0] > 0 || rem[1] > 0) begin
            int win;
            if (rem[0] > 0 && rem[1] > 0) win = 1 - last;
            else win = (rem[0] > 0) ? 0 : 1;
            exp_q.push_back(win);
            rem[win]--;
            last = win;
        end
        exp_last = last;
        for (int p = 0; p < 2; p++) begin
            ad1[p] = AW'($urandom_range(0, 31));
            ad2[p] = AW'($urandom_range(0, 31));
            if (n[p] > 0) set_req(p, 1'b1, 1'b0, ad1[p], ad2[p], '0);
        end
        while (order_q.size() < n0 + n1 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            checks++;
            if (r0_done && r1_done) begin
                failures++; $display("FAIL done_overlap: got r0_done=1 r1_done=1 required at most one");
            end
            checks++;
            if (rf_do_fetch && rf_do_write) begin
                failures++; $display("FAIL strobe_overlap: fetch=%b write=%b required not both", rf_do_fetch, rf_do_write);
            end
            for (int p = 0; p < 2; p++) begin
                if (done_of(p) === 1'b1) begin
                    order_q.push_back(p);
                    got[p]++;
                    checks++;
                    if (grant_id !== 1'(p)) begin
                        failures++; $display("FAIL resp_grant: got %b required %0d", grant_id, p);
                    end
                    checks++;
                    if (rd1_of(p) !== exp_mem[ad1[p]] || rd2_of(p) !== exp_mem[ad2[p]]) begin
                        failures++; $display("FAIL pair_rdata_port%0d: got %h/%h required %h/%h", p, rd1_of(p), rd2_of(p), exp_mem[ad1[p]], exp_mem[ad2[p]]);
                    end
                    exp_rd1[p] = exp_mem[ad1[p]];
                    exp_rd2[p] = exp_mem[ad2[p]];
                    if (got[p] >= n[p]) set_req(p, 1'b0, 1'b0, '0, '0, '0);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (order_q.size() != exp_q.size()) begin
            failures++; $display("FAIL pair_count: got %0d done pulses required %0d", order_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < order_q.size(); i++) begin
            checks++;
            if (order_q[i] != exp_q[i]) begin
                failures++; $display("FAIL grant_order[%0d]: got port %0d required port %0d", i, order_q[i], exp_q[i]);
            end
        end
        first_port = (order_q.size() > 0) ? order_q[0] : -1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clock);
        checks++;
        if ({r0_done, r1_done, rf_do_fetch, rf_do_write, rf_enable_write, busy, grant_id} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b required 0000000",
                                 {r0_done, r1_done, rf_do_fetch, rf_do_write, rf_enable_write, busy, grant_id});
        end
        checks++;
        if (rf_read_addr1 !== '0 || rf_read_addr2 !== '0 || rf_write_addr !== '0 || rf_write_data !== '0) begin
            failures++; $display("FAIL reset_rf: got %0d/%0d/%0d/%h required zeros", rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_data);
        end
        checks++;
        if ((r0_rdata1 | r0_rdata2 | r1_rdata1 | r1_rdata2) !== '0) begin
            failures++; $display("FAIL reset_rdata: got %h %h %h %h required 0", r0_rdata1, r0_rdata2, r1_rdata1, r1_rdata2);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got busy=%b grant=%b required 0/0", busy, grant_id);
        end
    endtask

    task automatic test_tie();
        int first;
        run_both(1, 1, first);
        checks++;
        if (first != 0) begin
            failures++; $display("FAIL first_tie: got port %0d required port 0", first);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        run_both(2, 2, first);
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF);
        do_txn(0, 1'b0, 5'd5, 5'd0, '0);
        checks++;
        if (r0_rdata1 !== 32'hDEADBEEF || r0_rdata2 !== 32'h0) begin
            failures++; $display("FAIL write_then_read: got %h/%h required deadbeef/00000000", r0_rdata1, r0_rdata2);
        end
    endtask

    task automatic test_other_port();
        do_txn(1, 1'b1, 5'd7, 5'd0, 32'h0000_1234);
        do_txn(1, 1'b0, 5'd7, 5'd7, '0);
        do_txn(0, 1'b1, 5'd3, 5'd0, 32'hA5A5_0003);
        do_txn(0, 1'b0, 5'd3, 5'd3, '0);
        checks++;
        if (r1_rdata1 !== 32'h0000_1234) begin
            failures++; $display("FAIL other_port_rdata: got %h required 00001234", r1_rdata1);
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 1'b0, 5'd7, 5'd3, '0);
        @(negedge clock);
        checks++;
        if (rf_do_fetch !== 1'b1 || grant_id !== 1'b1) begin
            failures++; $display("FAIL mid_fetch_state: got fetch=%b grant=%b required 1/1", rf_do_fetch, grant_id);
        end
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        exp_rd1[0] = '0; exp_rd2[0] = '0; exp_rd1[1] = '0; exp_rd2[1] = '0;
        exp_last = 1;
        checks++;
        if (rf_do_fetch !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 || r1_done !== 1'b0) begin
            failures++; $display("FAIL mid_reset_abort: got fetch=%b busy=%b grant=%b done=%b required 0000",
                                 rf_do_fetch, busy, grant_id, r1_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 1) reset = 1'b0;
            checks++;
            if (r1_done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL mid_reset_no_done: cycle %0d got done=%b busy=%b required 0/0", i, r1_done, busy);
            end
        end
        do_txn(1, 1'b0, 5'd7, 5'd3, '0);
    endtask

    task automatic test_r0_protect();
        logic [DW-1:0] want;
        want = PROTECT ? 32'h0 : 32'hFFFF_FFFF;
        do_txn(0, 1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        do_txn(0, 1'b0, 5'd0, 5'd0, '0);
        checks++;
        if (r0_rdata1 !== want) begin
            failures++; $display("FAIL addr0_write: got %h required %h", r0_rdata1, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int p;
            logic w;
            logic [AW-1:0] a1;
            logic [AW-1:0] a2;
            p  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a1 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 31));
            a2 = AW'($urandom_range(0, 31));
            do_txn(p, w, a1, a2, DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        for (int i = 0; i < 3; i++) begin
            int first;
            run_both(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), first);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            init_val[i] = (i == 0) ? '0 : DW'($urandom);
            exp_mem[i]  = init_val[i];
        end
        exp_rd1[0] = '0; exp_rd2[0] = '0; exp_rd1[1] = '0; exp_rd2[1] = '0;
        exp_last = 1;
        test_reset();
        test_tie();
        test_back_to_back();
        test_write_read();
        test_other_port();
        test_reset_mid();
        test_r0_protect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
